uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 Parameter CLKS_PER_BIT, default CLK_FREQ/BAUD_RATE (10416), clocks per bit; overridable directly for simulation.
REQ-004 Parameter LED_HOLD, default 5_000_000, LED on-time in clocks after a good frame.
REQ-005 clk  input  1  100 MHz system clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 rx  input  1  asynchronous UART serial input, idle high.
REQ-008 rx_data  output  8  last received data byte.
REQ-009 rx_valid  output  1  one-cycle pulse, good frame in rx_data.
REQ-010 rx_busy  output  1  high while a frame is being received.
REQ-011 parity_err  output  1  one-cycle pulse, parity mismatch on completed frame.
REQ-012 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-013 led  output  1  high for LED_HOLD clocks after each good frame.

Function
REQ-014 Frame SHALL be 11 bits: start(0), 8 data LSB first, even parity (XOR of data), stop(1), matching the team's uart_tx.
REQ-015 rx SHALL pass through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value rx_s.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE: clk_count=0, bit_index=0; rx_s==0 -> START.
REQ-018 START: count to CLKS_PER_BIT/2-1 (integer division); at terminal count, rx_s==0 -> DATA with clk_count cleared; rx_s==1 -> IDLE (glitch, no flags).
REQ-019 DATA: at each clk_count==CLKS_PER_BIT-1 sample rx_s into shift register bit bit_index, clear clk_count, increment bit_index; after bit_index 7 sampled -> PARITY.
REQ-020 PARITY: at CLKS_PER_BIT-1 latch rx_s as received parity -> STOP.
REQ-021 STOP: at CLKS_PER_BIT-1 sample rx_s; rx_data SHALL load the shift register on this cycle regardless of errors.
REQ-022 Stop sampled 1, parity matches: rx_valid pulses next cycle, -> IDLE.
REQ-023 Stop sampled 1, parity mismatch: parity_err pulses, rx_valid stays 0, -> IDLE.
REQ-024 Stop sampled 0: frame_err pulses (parity_err also pulses if mismatched), rx_valid 0, -> WAIT_HIGH.
REQ-025 WAIT_HIGH: remain until rx_s==1, then -> IDLE; a held-low line (break) SHALL never start a new frame.
REQ-026 Return to IDLE at mid-stop-bit SHALL allow a back-to-back start bit to be detected with no lost frame.
REQ-027 rx_busy SHALL be 1 in START, DATA, PARITY, STOP, WAIT_HIGH; 0 in IDLE.
REQ-028 Latency: rx_valid asserts 2 (sync) + 1 (pulse register) clocks after the stop-bit midpoint on the line.
REQ-029 clk_count SHALL be wide enough for CLKS_PER_BIT-1 (14 bits at default); bit_index 3 bits, wraps never reached.
REQ-030 LED: 24-bit counter loads LED_HOLD on rx_valid (reloads if already running); led=1 while counter>0; decrements each clock.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, synchronizer 1, rx_data 0x00, rx_valid 0, rx_busy 0, parity_err 0, frame_err 0, led 0, all counters 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no flags; after release the block waits in IDLE for a new falling edge.

Verification (CLKS_PER_BIT=16, LED_HOLD=100)
REQ-033 Send 0xA5, parity 0, stop 1 -> rx_valid one pulse, rx_data=0xA5, no error flags, led high 100 clocks.
REQ-034 Send 0x01 with parity bit 0 (wrong) -> parity_err pulse, rx_valid 0, rx_data=0x01, led stays 0.
REQ-035 Send 0x3C with stop bit 0, line held low 40 bit times -> one frame_err pulse, rx_busy 1 until line high, no further frames.
REQ-036 rx low pulse of 5 clocks in IDLE -> returns to IDLE, no flags, rx_busy high only during START.
REQ-037 Frames 0x55 then 0xFF back-to-back, no idle gap -> two rx_valid pulses, data 0x55 then 0xFF.
REQ-038 rst_n low during DATA bit 4 of 0x0F -> outputs reset values at once; next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 11-bit frames (start, 8 data LSB first, even parity, stop).
// The line is synchronized, sampled at mid-bit, and the outcome of each frame
// is reported as one-cycle pulses. An LED stretcher lights after good frames.
module uart_rx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int LED_HOLD     = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       led
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CW-1:0]   clk_count_q, clk_count_d;
    logic [2:0]      bit_index_q, bit_index_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic [23:0]     led_count_q;
    logic            par_mismatch;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Received parity compared against even parity of the assembled byte.
    assign par_mismatch = par_q != (^shift_q);

    // Next-state and datapath decisions, all made on the synchronized line.
    always_comb begin
        state_d      = state_q;
        clk_count_d  = clk_count_q;
        bit_index_d  = bit_index_q;
        shift_d      = shift_q;
        par_d        = par_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                clk_count_d = '0;
                bit_index_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit; a short low is a glitch.
                if (clk_count_q == HALF_LAST) begin
                    clk_count_d = '0;
                    state_d     = rx_s_q ? IDLE : DATA;
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end
            DATA: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = rx_s_q;
                    bit_index_d          = bit_index_q + 3'd1;
                    if (bit_index_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end
            PARITY: begin
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d = '0;
                    par_d       = rx_s_q;
                    state_d     = STOP;
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the next start.
                if (clk_count_q == BIT_LAST) begin
                    clk_count_d  = '0;
                    rx_data_d    = shift_q;
                    parity_err_d = par_mismatch;
                    if (rx_s_q) begin
                        rx_valid_d = !par_mismatch;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    clk_count_d = clk_count_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                // A break holds the line low; only a return high re-arms.
                clk_count_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, data and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clk_count_q  <= '0;
            bit_index_q  <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_count_q  <= clk_count_d;
            bit_index_q  <= bit_index_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // LED stretcher: (re)load on every good frame, count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_count_q <= '0;
        end else if (rx_valid_q) begin
            led_count_q <= 24'(LED_HOLD);
        end else if (led_count_q != 24'd0) begin
            led_count_q <= led_count_q - 24'd1;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_busy    = (state_q != IDLE);
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign led        = (led_count_q != 24'd0);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames from the requirements plus random
// frames, each outcome predicted from the frame-format rules.
module tb_uart_rx;

    localparam int CPB      = 16;
    localparam int LED_HOLD = 100;
    localparam int IDLE_GAP = 130;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_err;
    logic       frame_err;
    logic       led;

    uart_rx #(
        .CLK_FREQ    (100_000_000),
        .BAUD_RATE   (9600),
        .CLKS_PER_BIT(CPB),
        .LED_HOLD    (LED_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .led       (led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation counters, sampled on the falling edge.
    int         valid_total = 0;
    int         perr_total  = 0;
    int         ferr_total  = 0;
    int         led_total   = 0;
    int         busy_total  = 0;
    int         last_valid_cyc = 0;
    logic [7:0] data_log [0:255];

    always @(negedge clk) begin
        if (rx_valid) begin
            data_log[valid_total % 256] <= rx_data;
            valid_total    <= valid_total + 1;
            last_valid_cyc <= cyc;
        end
        if (parity_err) perr_total <= perr_total + 1;
        if (frame_err)  ferr_total <= ferr_total + 1;
        if (led)        led_total  <= led_total + 1;
        if (rx_busy)    busy_total <= busy_total + 1;
    end

    int tests_run = 0;
    int errors    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int v0, p0, f0, l0, b0, frame_t0;

    task automatic snap();
        v0 = valid_total;
        p0 = perr_total;
        f0 = ferr_total;
        l0 = led_total;
        b0 = busy_total;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        frame_t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    // Send one frame, optionally hold the line low afterwards, and check the
    // outcome predicted from the frame rules.
    task automatic run_frame(input logic [7:0] d, input logic par, input logic stop,
                             input int hold_bits);
        logic exp_perr, exp_valid, exp_ferr;
        exp_perr  = (par != (^d));
        exp_valid = stop && !exp_perr;
        exp_ferr  = !stop;
        snap();
        send_frame(d, par, stop);
        for (int i = 0; i < hold_bits; i++) send_bit(1'b0);
        if (hold_bits > 0) check("busy_during_break", 32'(rx_busy), 32'd1);
        idle(IDLE_GAP);
        $display("[TB] frame data=%02h par=%0b stop=%0b hold=%0d valid=%0d perr=%0d ferr=%0d",
                 d, par, stop, hold_bits, valid_total - v0, perr_total - p0, ferr_total - f0);
        check("valid_count", 32'(valid_total - v0), 32'(exp_valid));
        check("perr_count", 32'(perr_total - p0), 32'(exp_perr));
        check("ferr_count", 32'(ferr_total - f0), 32'(exp_ferr));
        check("rx_data", 32'(rx_data), 32'(d));
        check("busy_after", 32'(rx_busy), 32'd0);
        if (exp_valid) begin
            check("valid_data", 32'(data_log[v0 % 256]), 32'(d));
            check("valid_latency", 32'(last_valid_cyc - frame_t0), 32'(10 * CPB + CPB / 2 + 3));
            check("led_cycles", 32'(led_total - l0), 32'(LED_HOLD));
        end else begin
            check("led_cycles", 32'(led_total - l0), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       par, stop;
        int         hold;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Good frame, parity error, break
        run_frame(8'hA5, 1'b0, 1'b1, 0);
        run_frame(8'h01, 1'b0, 1'b1, 0);
        run_frame(8'h3C, 1'b0, 1'b0, 40);

        // Short glitch in idle
        snap();
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        $display("[TB] glitch busy_cycles=%0d", busy_total - b0);
        check("glitch_busy", 32'(busy_total - b0), 32'(CPB / 2));
        check("glitch_valid", 32'(valid_total - v0), 32'd0);
        check("glitch_perr", 32'(perr_total - p0), 32'd0);
        check("glitch_ferr", 32'(ferr_total - f0), 32'd0);

        // Back-to-back frames, no idle gap
        snap();
        send_frame(8'h55, ^8'h55, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        idle(IDLE_GAP);
        $display("[TB] back-to-back 55,FF valid=%0d", valid_total - v0);
        check("b2b_count", 32'(valid_total - v0), 32'd2);
        check("b2b_data0", 32'(data_log[v0 % 256]), 32'h55);
        check("b2b_data1", 32'(data_log[(v0 + 1) % 256]), 32'hFF);
        check("b2b_perr", 32'(perr_total - p0), 32'd0);
        check("b2b_ferr", 32'(ferr_total - f0), 32'd0);

        // Reset in the middle of data bit 4 of 0x0F
        snap();
        d = 8'h0F;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        repeat (CPB / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        $display("[TB] reset mid-frame rx_data=%02h busy=%0b", rx_data, rx_busy);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_led", 32'(led), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(40);
        check("midrst_no_valid", 32'(valid_total - v0), 32'd0);
        check("midrst_no_perr", 32'(perr_total - p0), 32'd0);
        check("midrst_no_ferr", 32'(ferr_total - f0), 32'd0);
        check("midrst_idle", 32'(rx_busy), 32'd0);
        run_frame(8'h81, ^8'h81, 1'b1, 0);

        // Random frames
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom);
            par  = (^d) ^ (($urandom % 4) == 0);
            stop = ($urandom % 5) != 0;
            hold = stop ? 0 : int'($urandom_range(1, 3));
            run_frame(d, par, stop, hold);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
